// File: rtl/tdm_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer.
package tdm_pkg;

  localparam int N_CH   = 4;
  localparam int SLOT_W = 2;

  localparam logic [SLOT_W-1:0] SLOT_A = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT_B = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT_C = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT_D = 2'd3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_frame_reg.sv
// Shadow registers for channels a..c plus the output bank that publishes a whole frame at once.
module tdm_frame_reg
  import tdm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              shadow_ld,
  input  logic [SLOT_W-1:0] shadow_idx,
  input  logic              out_ld,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic [WIDTH-1:0]  out_c,
  output logic [WIDTH-1:0]  out_d
);

  logic [WIDTH-1:0] shadow_q [N_CH-1];
  logic [WIDTH-1:0] shadow_d [N_CH-1];
  logic [WIDTH-1:0] ch_q     [N_CH];
  logic [WIDTH-1:0] ch_d     [N_CH];

  always_comb begin
    shadow_d = shadow_q;
    ch_d     = ch_q;
    if (shadow_ld) begin
      case (shadow_idx)
        SLOT_A:  shadow_d[0] = din;
        SLOT_B:  shadow_d[1] = din;
        SLOT_C:  shadow_d[2] = din;
        default: ;
      endcase
    end
    // The slot-3 beat goes straight to out_d; it never needs a shadow.
    if (out_ld) begin
      ch_d[0] = shadow_q[0];
      ch_d[1] = shadow_q[1];
      ch_d[2] = shadow_q[2];
      ch_d[3] = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '{default: '0};
      ch_q     <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
      ch_q     <= ch_d;
    end
  end

  assign out_a = ch_q[0];
  assign out_b = ch_q[1];
  assign out_c = ch_q[2];
  assign out_d = ch_q[3];

endmodule

// File: rtl/tdm_demux14.sv
// 1:4 TDM demultiplexer: frame-sync FSM and slot counter around tdm_frame_reg.
// Optional saturating sync-error counter on err_cnt when TDM_DEMUX_ERRCNT_EN is defined.
//
// state  | meaning
// HUNT   | waiting for a beat with sof; other beats are discarded
// LOCKED | tracking slots 0..3, assembling frames
module tdm_demux14
  import tdm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  input  logic              sof,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic [WIDTH-1:0]  out_c,
  output logic [WIDTH-1:0]  out_d,
  output logic              frame_valid,
`ifdef TDM_DEMUX_ERRCNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              sync_err,
  output logic              locked,
  output logic [SLOT_W-1:0] slot
);

  tdm_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              frame_valid_q, frame_valid_d;
  logic              sync_err_q, sync_err_d;
  logic              shadow_ld;
  logic [SLOT_W-1:0] shadow_idx;
  logic              out_ld;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    shadow_ld     = 1'b0;
    shadow_idx    = SLOT_A;
    out_ld        = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (sof) begin
            shadow_ld = 1'b1;
            slot_d    = SLOT_B;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (sof) begin
            // Early sof restarts the frame; the stale shadows are overwritten later.
            sync_err_d = (slot_q != SLOT_A);
            shadow_ld  = 1'b1;
            slot_d     = SLOT_B;
          end else if (slot_q == SLOT_A) begin
            sync_err_d = 1'b1;
            slot_d     = SLOT_A;
            state_d    = HUNT;
          end else if (slot_q == SLOT_D) begin
            out_ld        = 1'b1;
            frame_valid_d = 1'b1;
            slot_d        = SLOT_A;
          end else begin
            shadow_ld  = 1'b1;
            shadow_idx = slot_q;
            slot_d     = slot_q + SLOT_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= SLOT_A;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  tdm_frame_reg #(.WIDTH(WIDTH)) u_frame_reg (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .shadow_ld  (shadow_ld),
    .shadow_idx (shadow_idx),
    .out_ld     (out_ld),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_d      (out_d)
  );

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (sync_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);
  assign slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux14.sv
// Scoreboard bench for tdm_demux14: expected frames and sync errors are queued at stimulus time
// and popped by a monitor whenever the DUT strobes frame_valid or sync_err.
module tb_tdm_demux14;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
  } frame_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         sof = 1'b0;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic         frame_valid, sync_err, locked;
  logic [1:0]   slot;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0]   err_cnt;
  int           err_model = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  frame_t frame_q[$];
  int     err_q[$];
  bit     done = 1'b0;

  always #5 clk = ~clk;

  tdm_demux14 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_c       (out_c),
    .out_d       (out_d),
    .frame_valid (frame_valid),
`ifdef TDM_DEMUX_ERRCNT_EN
    .err_cnt     (err_cnt),
`endif
    .sync_err    (sync_err),
    .locked      (locked),
    .slot        (slot)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves the next call aligned to the next cycle.
  task automatic beat(input logic [W-1:0] d, input logic s);
    din       = d;
    din_valid = 1'b1;
    sof       = s;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_err();
    err_q.push_back(1);
`ifdef TDM_DEMUX_ERRCNT_EN
    if (err_model < 255) err_model++;
`endif
  endtask

  task automatic chk_outs(input string name, input frame_t f);
    chk({name, ".out_a"}, 32'(out_a), 32'(f.a));
    chk({name, ".out_b"}, 32'(out_b), 32'(f.b));
    chk({name, ".out_c"}, 32'(out_c), 32'(f.c));
    chk({name, ".out_d"}, 32'(out_d), 32'(f.d));
  endtask

  // Monitor: sample mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!done) begin
      if (frame_valid && sync_err) chk("strobe_exclusive", 32'(1), 32'(0));
      if (frame_valid) begin
        if (frame_q.size() == 0) begin
          chk("unexpected_frame_valid", 32'(1), 32'(0));
        end else begin
          frame_t e;
          e = frame_q.pop_front();
          chk("frame", {16'h0, out_a, out_b, out_c, out_d}, {16'h0, e});
        end
      end
      if (sync_err) begin
        if (err_q.size() == 0) chk("unexpected_sync_err", 32'(1), 32'(0));
        else chk("sync_err", 32'(sync_err), 32'(err_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f1, f2, f3, f5, f6;
    f1 = {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    f2 = {4'b1100, 4'b0011, 4'b0110, 4'b1001};
    f3 = {4'b0101, 4'b1010, 4'b1111, 4'b0000};
    f5 = {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    f6 = {4'b1001, 4'b0110, 4'b0011, 4'b1100};

    idle(2);
    chk_outs("reset", '0);
    chk("reset.locked", 32'(locked), 32'(0));
    chk("reset.slot", 32'(slot), 32'(0));
    chk("reset.frame_valid", 32'(frame_valid), 32'(0));
    chk("reset.sync_err", 32'(sync_err), 32'(0));
    rst = 1'b0;
    idle(1);

    // Beats without sof are discarded while hunting.
    beat(4'b1111, 1'b0);
    beat(4'b1010, 1'b0);
    beat(4'b0110, 1'b0);
    beat(4'b0011, 1'b0);
    chk("hunt.locked", 32'(locked), 32'(0));
    chk("hunt.slot", 32'(slot), 32'(0));
    chk_outs("hunt", '0);

    // Frame 1, back to back.
    beat(f1.a, 1'b1);
    chk("lock.locked", 32'(locked), 32'(1));
    chk("lock.slot", 32'(slot), 32'(1));
    beat(f1.b, 1'b0);
    beat(f1.c, 1'b0);
    frame_q.push_back(f1);
    beat(f1.d, 1'b0);
    chk("f1.slot", 32'(slot), 32'(0));
    idle(1);
    chk("f1.strobe_gone", 32'(frame_valid), 32'(0));

    // Frame 2 with 2-cycle gaps; outputs must hold frame 1 until the last beat.
    beat(f2.a, 1'b1); idle(2);
    beat(f2.b, 1'b0); idle(2);
    beat(f2.c, 1'b0); idle(2);
    chk_outs("f2.hold", f1);
    chk("f2.slot3", 32'(slot), 32'(3));
    frame_q.push_back(f2);
    beat(f2.d, 1'b0);
    idle(2);
    chk_outs("f2.after", f2);

    // Early sof at slot 2.
    beat(4'b0001, 1'b1);
    beat(4'b0010, 1'b0);
    push_err();
    beat(f3.a, 1'b1);
    chk("resync.locked", 32'(locked), 32'(1));
    chk("resync.slot", 32'(slot), 32'(1));
    chk_outs("resync.hold", f2);
    beat(f3.b, 1'b0);
    beat(f3.c, 1'b0);
    frame_q.push_back(f3);
    beat(f3.d, 1'b0);

    // Lost frame marker at slot 0.
    push_err();
    beat(4'b0111, 1'b0);
    chk("lost.locked", 32'(locked), 32'(0));
    chk("lost.slot", 32'(slot), 32'(0));
    chk_outs("lost.hold", f3);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("lost.err_cnt", 32'(err_cnt), 32'(err_model));
`endif
    idle(1);

    // Reset asserted mid-frame after the slot-2 beat.
    beat(4'b0011, 1'b1);
    beat(4'b0100, 1'b0);
    beat(4'b0101, 1'b0);
    rst = 1'b1;
    #2;
    chk_outs("async_rst", '0);
    chk("async_rst.locked", 32'(locked), 32'(0));
    chk("async_rst.slot", 32'(slot), 32'(0));
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("async_rst.err_cnt", 32'(err_cnt), 32'(0));
    err_model = 0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Full frame after reset, then another at full rate.
    beat(f5.a, 1'b1);
    beat(f5.b, 1'b0);
    beat(f5.c, 1'b0);
    frame_q.push_back(f5);
    beat(f5.d, 1'b0);
    beat(f6.a, 1'b1);
    beat(f6.b, 1'b0);
    beat(f6.c, 1'b0);
    frame_q.push_back(f6);
    beat(f6.d, 1'b0);
    idle(1);
    chk_outs("b2b.final", f6);

    // Repeated early sof: the first is a normal start, each following one is an error.
    for (int i = 0; i < 301; i++) begin
      if (i > 0) push_err();
      beat(W'(i), 1'b1);
    end
    idle(2);
    chk("resync_storm.locked", 32'(locked), 32'(1));
    chk_outs("resync_storm.hold", f6);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("err_cnt.saturate", 32'(err_cnt), 32'(8'hFF));
`endif

    idle(3);
    chk("frames_outstanding", 32'(frame_q.size()), 32'(0));
    chk("errs_outstanding", 32'(err_q.size()), 32'(0));
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
